// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sample width, complex sample type and delay-length clamp.
package fft_pkg;

  localparam int unsigned DefaultDataW = 16;

  typedef struct packed {
    logic signed [DefaultDataW-1:0] re;
    logic signed [DefaultDataW-1:0] im;
  } cplx_t;

  // Zero means "one tap"; anything longer than the RAM is capped at the RAM depth.
  function automatic int unsigned clamp_len(int unsigned len, int unsigned max_depth);
    if (len == 0) return 1;
    if (len > max_depth) return max_depth;
    return len;
  endfunction

endpackage

// File: rtl/delay_dpram.sv
// Simple dual-port RAM, read-first, registered read data, no reset.
module delay_dpram #(
  parameter int unsigned Depth = 512,
  parameter int unsigned Width = 32,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Both in one block so a same-address read returns the pre-write word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/delay_ram_line.sv
// Runtime-programmable complex delay line on a circular RAM buffer.
// Optional fill tracking / output gating via macro DELAY_PRIMED_EN.
module delay_ram_line
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned MAX_DEPTH = 512,
  parameter int unsigned LEN_W     = $clog2(MAX_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     cfg_load,
  input  logic [LEN_W-1:0]         delay_len,
  input  logic signed [DATA_W-1:0] x_in_re,
  input  logic signed [DATA_W-1:0] x_in_im,
  output logic signed [DATA_W-1:0] x_out_re,
  output logic signed [DATA_W-1:0] x_out_im,
  output logic                     primed
);

  localparam int unsigned AW = $clog2(MAX_DEPTH);

  logic [LEN_W-1:0]    lq_q, lq_d;
  logic [AW-1:0]       wp_q, wp_d;
  logic                out_zero_q, out_zero_d;
  logic [2*DATA_W-1:0] byp_q, byp_d;
  logic [2*DATA_W-1:0] ram_rdata, x_sel;
  logic [AW-1:0]       raddr;
  logic                adv;

  assign adv   = enable && !cfg_load;
  assign raddr = wp_q - AW'(lq_q - LEN_W'(1));

`ifdef DELAY_PRIMED_EN
  logic [LEN_W-1:0] fill_q, fill_d;

  always_comb begin
    fill_d = fill_q;
    if (cfg_load) begin
      fill_d = '0;
    end else if (enable && (fill_q < lq_q)) begin
      fill_d = fill_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fill_q <= '0;
    else        fill_q <= fill_d;
  end

  assign primed = (fill_q == lq_q);
`else
  assign primed = 1'b1;
`endif

  always_comb begin
    lq_d       = lq_q;
    wp_d       = wp_q;
    out_zero_d = out_zero_q;
    byp_d      = byp_q;
    if (cfg_load) begin
      lq_d       = LEN_W'(clamp_len(32'(delay_len), MAX_DEPTH));
      wp_d       = '0;
      out_zero_d = 1'b1;
    end else if (enable) begin
      wp_d  = wp_q + AW'(1);
      byp_d = {x_in_re, x_in_im};
`ifdef DELAY_PRIMED_EN
      out_zero_d = (fill_d != lq_q);
`else
      out_zero_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lq_q       <= LEN_W'(MAX_DEPTH);
      wp_q       <= '0;
      out_zero_q <= 1'b1;
    end else begin
      lq_q       <= lq_d;
      wp_q       <= wp_d;
      out_zero_q <= out_zero_d;
    end
  end

  // Bypass register only matters for Lq=1, where the RAM read would see the old word.
  always_ff @(posedge clk) begin
    byp_q <= byp_d;
  end

  delay_dpram #(
    .Depth (MAX_DEPTH),
    .Width (2 * DATA_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (adv),
    .waddr_i (wp_q),
    .wdata_i ({x_in_re, x_in_im}),
    .re_i    (adv),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    x_sel    = (lq_q == LEN_W'(1)) ? byp_q : ram_rdata;
    x_out_re = out_zero_q ? '0 : x_sel[2*DATA_W-1:DATA_W];
    x_out_im = out_zero_q ? '0 : x_sel[DATA_W-1:0];
  end

endmodule

// File: tb/tb_delay_ram_line.sv
// Directed bench for delay_ram_line with a reference delay model feeding a scoreboard queue.
module tb_delay_ram_line;
  import fft_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned MD = 512;
  localparam int unsigned LW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n, enable, cfg_load;
  logic [LW-1:0]        delay_len;
  logic signed [DW-1:0] x_in_re, x_in_im, x_out_re, x_out_im;
  logic                 primed;

  always #5 clk = ~clk;

  delay_ram_line #(
    .DATA_W    (DW),
    .MAX_DEPTH (MD),
    .LEN_W     (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_load  (cfg_load),
    .delay_len (delay_len),
    .x_in_re   (x_in_re),
    .x_in_im   (x_in_im),
    .x_out_re  (x_out_re),
    .x_out_im  (x_out_im),
    .primed    (primed)
  );

  typedef struct packed {
    logic  chk;
    cplx_t d;
    logic  pr;
  } sb_t;

  sb_t         sb[$];
  cplx_t       hist[$];
  int unsigned lq_m, k_m;
  cplx_t       cur;
  logic        cur_ok;
  int          total = 0;
  int          bad = 0;
  int          n = 1;
  string       tag;

  function automatic int unsigned model_clamp(int unsigned l);
    if (l == 0) return 1;
    else if (l > MD) return MD;
    else return l;
  endfunction

  // One clock edge: drive inputs, advance the model, push the expectation, then pop and compare.
  task automatic step(input logic rst, input logic ld, input logic en, input int unsigned len);
    sb_t e;
    rst_n     = !rst;
    cfg_load  = ld;
    enable    = en;
    delay_len = LW'(len);
    x_in_re   = DW'(n);
    x_in_im   = DW'(-n);
    if (rst || ld) begin
      lq_m = rst ? MD : model_clamp(len);
      k_m  = 0;
      hist.delete();
      cur    = '0;
      cur_ok = 1'b1;
    end else if (en) begin
      k_m++;
      hist.push_back(cplx_t'{re: x_in_re, im: x_in_im});
      if (hist.size() > lq_m) void'(hist.pop_front());
      if (k_m >= lq_m) begin
        cur    = hist[0];
        cur_ok = 1'b1;
      end else begin
`ifdef DELAY_PRIMED_EN
        cur    = '0;
        cur_ok = 1'b1;
`else
        cur_ok = 1'b0;
`endif
      end
    end
    e.chk = cur_ok;
    e.d   = cur;
`ifdef DELAY_PRIMED_EN
    e.pr  = (k_m >= lq_m);
`else
    e.pr  = 1'b1;
`endif
    sb.push_back(e);
    n++;
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    if (e.chk) begin
      total++;
      assert (x_out_re === e.d.re) else begin
        bad++;
        $error("FAIL %s x_out_re got=%0d exp=%0d", tag, x_out_re, e.d.re);
      end
      total++;
      assert (x_out_im === e.d.im) else begin
        bad++;
        $error("FAIL %s x_out_im got=%0d exp=%0d", tag, x_out_im, e.d.im);
      end
    end
    total++;
    assert (primed === e.pr) else begin
      bad++;
      $error("FAIL %s primed got=%0b exp=%0b", tag, primed, e.pr);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; cfg_load = 1'b0; delay_len = '0;
    x_in_re = '0; x_in_im = '0;

    tag = "reset";
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);

    tag = "len4";
    step(1'b0, 1'b1, 1'b0, 4);
    n = 1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 0);

    // Delay counted in enabled edges; delay_len wiggles without cfg_load must be ignored.
    tag = "gated_len3";
    step(1'b0, 1'b1, 1'b1, 3);
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b0, ((i % 4) == 0) || ((i % 4) == 3), $urandom_range(0, 1023));
    end

    tag = "len1";
    step(1'b0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 0);

    tag = "len512_wrap";
    step(1'b0, 1'b1, 1'b0, 512);
    n = 1;
    for (int i = 0; i < 1200; i++) step(1'b0, 1'b0, 1'b1, 0);

    tag = "len0_clamp";
    step(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 0);

    tag = "len600_clamp";
    step(1'b0, 1'b1, 1'b0, 600);
    for (int i = 0; i < 520; i++) step(1'b0, 1'b0, 1'b1, 0);

    tag = "midload_len8";
    step(1'b0, 1'b1, 1'b0, 5);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 8);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 0);

    tag = "midreset";
    step(1'b0, 1'b1, 1'b0, 4);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 0);
    tag = "reload_len4";
    step(1'b0, 1'b1, 1'b0, 4);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
